// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the debug-unit CPU: turns the run switch and step button
// into a per-cycle CPU enable, with burst stepping, one PC breakpoint and a retire counter.
module cpu_run_ctrl #(
    parameter int PC_W    = 32,
    parameter int BURST_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               succ,
    input  logic               step,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_en,
    output logic               halted,
    output logic               brk_hit,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   instr_cnt
);

    // state | meaning
    // HALT  | CPU frozen, waiting for run switch or step press
    // RUN   | free run until switch drops or breakpoint PC is reached
    // STEP  | executing a burst of step_rem+1 instructions
    // BRK   | stopped in front of the breakpoint instruction
    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_BRK  = 2'd3
    } state_t;

    state_t             state_q;
    logic               succ_m, succ_s;
    logic               step_m, step_s, step_d;
    logic               step_edg;
    logic               first;
    logic               bp_match;
    logic [BURST_W-1:0] step_rem;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            succ_m <= 1'b0;
            succ_s <= 1'b0;
            step_m <= 1'b0;
            step_s <= 1'b0;
            step_d <= 1'b0;
        end else begin
            succ_m <= succ;
            succ_s <= succ_m;
            step_m <= step;
            step_s <= step_m;
            step_d <= step_s;
        end
    end

    assign step_edg = step_s & ~step_d;

    // first masks the breakpoint so a resume from the bp PC executes it once
    assign bp_match = bp_en & (pc == bp_addr) & ~first;

    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            S_STEP:  cpu_en = 1'b1;
            S_RUN:   cpu_en = ~bp_match;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HALT;
            first    <= 1'b0;
            step_rem <= '0;
            halted   <= 1'b1;
            brk_hit  <= 1'b0;
        end else begin
            case (state_q)
                S_HALT: begin
                    if (succ_s) begin
                        state_q <= S_RUN;
                        first   <= 1'b1;
                        halted  <= 1'b0;
                    end else if (step_edg) begin
                        state_q  <= S_STEP;
                        step_rem <= (burst_len == '0) ? '0 : burst_len - 1'b1;
                        halted   <= 1'b0;
                    end
                end
                S_RUN: begin
                    first <= 1'b0;
                    if (!succ_s) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                    end else if (bp_match) begin
                        state_q <= S_BRK;
                        halted  <= 1'b1;
                        brk_hit <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (step_rem == '0) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        step_rem <= step_rem - 1'b1;
                    end
                end
                S_BRK: begin
                    if (!succ_s) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                        brk_hit <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_HALT;
                    halted  <= 1'b1;
                    brk_hit <= 1'b0;
                end
            endcase
        end
    end

    // assigned every cycle so the counter wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, cpu_en};
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: step/burst, run with breakpoint, resume,
// async reset, succ/step priority and counter wrap.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst;
    logic        succ;
    logic        step;
    logic [7:0]  burst_len;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic        brk_hit;
    logic [1:0]  state;
    logic [31:0] instr_cnt;
    logic [31:0] en_cnt;

    int errors = 0;
    int checks = 0;

    cpu_run_ctrl #(.PC_W(32), .BURST_W(8), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .succ      (succ),
        .step      (step),
        .burst_len (burst_len),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .brk_hit   (brk_hit),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple CPU stand-in: PC advances by 4 on each enabled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= 32'h0;
            en_cnt <= 32'h0;
        end else if (cpu_en) begin
            pc     <= pc + 32'd4;
            en_cnt <= en_cnt + 32'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; succ = 1'b0; step = 1'b0;
        burst_len = 8'd0; bp_en = 1'b0; bp_addr = 32'h0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_state",   32'(state),   32'd0);
        check("rst_cpu_en",  32'(cpu_en),  32'd0);
        check("rst_halted",  32'(halted),  32'd1);
        check("rst_brk_hit", 32'(brk_hit), 32'd0);
        check("rst_cnt",     instr_cnt,    32'd0);

        // single step with burst_len=0
        step = 1'b1;
        tick(3);
        check("step1_state",  32'(state),  32'd2);
        check("step1_cpu_en", 32'(cpu_en), 32'd1);
        tick(1);
        check("step1_back_halt", 32'(state), 32'd0);
        check("step1_cnt",       instr_cnt,  32'd1);
        step = 1'b0;
        tick(4);
        check("step1_en_total", en_cnt,      32'd1);
        check("step1_idle",     32'(state),  32'd0);

        // burst of 5
        burst_len = 8'd5;
        step = 1'b1;
        tick(3);
        check("burst5_enter", 32'(state), 32'd2);
        tick(4);
        check("burst5_still_step", 32'(state), 32'd2);
        tick(1);
        check("burst5_halt", 32'(state), 32'd0);
        check("burst5_cnt",  instr_cnt,  32'd6);
        step = 1'b0;
        tick(4);
        check("burst5_en_total", en_cnt, 32'd6);

        // burst of 4 with a second press arriving mid-burst
        burst_len = 8'd4;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        check("burst4_enter", 32'(state), 32'd2);
        step = 1'b1;
        tick(3);
        check("burst4_still_step", 32'(state), 32'd2);
        tick(1);
        check("burst4_halt", 32'(state), 32'd0);
        check("burst4_cnt",  instr_cnt,  32'd10);
        step = 1'b0;
        tick(4);
        check("burst4_no_restep", 32'(state), 32'd0);
        check("burst4_en_total",  en_cnt,     32'd10);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.cnt_q;
        #1;
        check("wrap_preset", instr_cnt, 32'hFFFF_FFFF);
        burst_len = 8'd1;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        check("wrap_step", 32'(state), 32'd2);
        tick(1);
        check("wrap_cnt", instr_cnt, 32'd0);
        tick(3);

        // async reset in the middle of RUN
        succ = 1'b1;
        tick(3);
        check("run_enter",  32'(state),  32'd1);
        check("run_cpu_en", 32'(cpu_en), 32'd1);
        tick(2);
        #3 rst = 1'b1;
        #1;
        check("arst_state",  32'(state),  32'd0);
        check("arst_cpu_en", 32'(cpu_en), 32'd0);
        check("arst_cnt",    instr_cnt,   32'd0);
        check("arst_halted", 32'(halted), 32'd1);
        succ = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);

        // breakpoint at 0x0C, then resume from it
        bp_addr = 32'h0C;
        bp_en   = 1'b1;
        succ    = 1'b1;
        tick(3);
        check("bp_run_state", 32'(state),  32'd1);
        check("bp_run_pc",    pc,          32'h0);
        tick(3);
        check("bp_match_pc",     pc,          32'h0C);
        check("bp_match_cpu_en", 32'(cpu_en), 32'd0);
        tick(1);
        check("brk_state",   32'(state),   32'd3);
        check("brk_hit",     32'(brk_hit), 32'd1);
        check("brk_halted",  32'(halted),  32'd1);
        check("brk_cpu_en",  32'(cpu_en),  32'd0);
        check("brk_pc_held", pc,           32'h0C);
        check("brk_cnt",     instr_cnt,    32'd3);
        succ = 1'b0;
        tick(3);
        check("brk_exit_state", 32'(state),   32'd0);
        check("brk_exit_flag",  32'(brk_hit), 32'd0);
        succ = 1'b1;
        tick(3);
        check("resume_state",  32'(state),  32'd1);
        check("resume_cpu_en", 32'(cpu_en), 32'd1);
        check("resume_pc",     pc,          32'h0C);
        tick(2);
        check("resume_pc_on", pc,        32'h14);
        check("resume_cnt",   instr_cnt, 32'd5);
        succ = 1'b0;
        tick(3);
        check("run_stop_state", 32'(state), 32'd0);
        check("run_stop_cnt",   instr_cnt,  32'd8);
        check("run_stop_pc",    pc,         32'h20);

        // succ and step edge arriving together from HALT
        bp_en = 1'b0;
        succ  = 1'b1;
        step  = 1'b1;
        tick(3);
        check("prio_state",  32'(state),  32'd1);
        check("prio_cpu_en", 32'(cpu_en), 32'd1);
        succ = 1'b0;
        step = 1'b0;
        tick(3);
        check("prio_halt", 32'(state), 32'd0);
        check("prio_cnt",  instr_cnt,  32'd11);
        tick(3);
        check("prio_idle_cnt", instr_cnt, 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
